svm_classifier: RTL and testbench



---
 rtl/svm_classifier.sv | 264 ++++++++++++++++++++++++++
 tb/tb_svm_classifier.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_classifier.sv
// svm_classifier
//
// Linear-kernel support-vector classifier. A model (support vectors,
// per-vector weights, bias) is uploaded as a little-endian byte stream.
// Feature vectors are streamed in one sample per cycle. Each completed
// vector is scored sequentially with one multiply per cycle, and the sign
// of the score drives the detection flag.
//
// Ports:
//   clk_in             system clock
//   rst_in             synchronous active-high reset
//   feature_data_in    signed 16-bit feature sample
//   feature_valid_in   feature sample valid
//   feature_last_in    final sample of a vector (qualified by valid)
//   ble_data_in        model upload byte
//   ble_valid_in       upload byte strobe
//   predict_enable_in  feature samples are accepted only while high
//   detected_out       result of the most recent classification
//
// Upload FSM
//   state      | meaning
//   LOAD_COUNT | waiting for the support-vector count byte
//   LOAD_VEC   | consuming NF sv bytes + 2 weight bytes per vector
//   LOAD_BIAS  | consuming 4 bias bytes, LSB first
//   READY      | model loaded; a new byte restarts the upload
//
// Compute FSM
//   state  | meaning
//   C_IDLE | accepting feature samples
//   C_INIT | score <= bias, counters cleared
//   C_MAC  | acc += sv[i][j] * x[j], one feature per cycle
//   C_ADD  | score += w[i] * acc
//   C_DONE | detected_out <= (score > 0)

module svm_classifier #(
    parameter int NUM_FEATURES_IN     = 16,
    parameter int MAX_SUPPORT_VECTORS = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] feature_data_in,
    input  logic        feature_valid_in,
    input  logic        feature_last_in,
    input  logic [7:0]  ble_data_in,
    input  logic        ble_valid_in,
    input  logic        predict_enable_in,
    output logic        detected_out
);

    localparam int NF  = NUM_FEATURES_IN;
    localparam int MSV = MAX_SUPPORT_VECTORS;
    localparam int FW  = $clog2(NF);        // feature index
    localparam int IW  = $clog2(NF + 1);    // capture index, saturates at NF
    localparam int BW  = $clog2(NF + 2);    // byte index within an uploaded vector
    localparam int SVW = $clog2(MSV);       // support-vector memory index
    localparam int NW  = $clog2(MSV + 1);   // stored vector count

    typedef enum logic [1:0] {LOAD_COUNT, LOAD_VEC, LOAD_BIAS, READY} load_state_t;
    typedef enum logic [2:0] {C_IDLE, C_INIT, C_MAC, C_ADD, C_DONE} comp_state_t;

    load_state_t load_state, load_next;
    comp_state_t comp_state, comp_next;

    // model storage
    logic [7:0]         n_raw;
    logic [NW-1:0]      n_sv;
    logic [7:0]         vec_cnt;
    logic [BW-1:0]      byte_cnt;
    logic [1:0]         bias_cnt;
    logic signed [31:0] bias;
    logic signed [7:0]  sv_mem [MSV][NF];
    logic signed [15:0] w_mem  [MSV];

    logic wr_count, wr_vec, wr_bias, abort;
    logic vec_end, last_vec, model_loaded;

    // feature capture and compute
    logic signed [15:0] feat_buf [NF];
    logic [IW-1:0]      feat_idx;
    logic [FW-1:0]      feat_j;
    logic [NW-1:0]      sv_i;
    logic [SVW-1:0]     sv_sel;
    logic signed [31:0] acc;
    logic signed [47:0] score;
    logic signed [31:0] mac_prod;
    logic signed [47:0] add_prod;
    logic signed [7:0]  sv_cur;
    logic signed [15:0] x_cur;
    logic signed [15:0] w_cur;
    logic accept, vec_done, start, clear_buf;
    logic init_en, mac_en, add_en, done_en;

    assign vec_end      = (byte_cnt == BW'(NF + 1));
    assign last_vec     = (vec_cnt == n_raw - 8'd1);
    assign model_loaded = (load_state == READY);

    // ---------------- upload FSM ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) load_state <= LOAD_COUNT;
        else        load_state <= load_next;
    end

    always_comb begin
        load_next = load_state;
        if (ble_valid_in) begin
            case (load_state)
                LOAD_COUNT, READY: load_next = (ble_data_in == 8'd0) ? LOAD_BIAS : LOAD_VEC;
                LOAD_VEC:          if (vec_end && last_vec) load_next = LOAD_BIAS;
                LOAD_BIAS:         if (bias_cnt == 2'd3) load_next = READY;
                default:           load_next = LOAD_COUNT;
            endcase
        end
    end

    always_comb begin
        wr_count = 1'b0;
        wr_vec   = 1'b0;
        wr_bias  = 1'b0;
        abort    = 1'b0;
        if (ble_valid_in) begin
            case (load_state)
                LOAD_COUNT: wr_count = 1'b1;
                READY: begin
                    // a byte in READY is the count of a fresh upload
                    wr_count = 1'b1;
                    abort    = 1'b1;
                end
                LOAD_VEC:   wr_vec  = 1'b1;
                LOAD_BIAS:  wr_bias = 1'b1;
                default:    wr_count = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            n_raw    <= '0;
            n_sv     <= '0;
            vec_cnt  <= '0;
            byte_cnt <= '0;
            bias_cnt <= '0;
            bias     <= '0;
        end else begin
            if (wr_count) begin
                n_raw    <= ble_data_in;
                n_sv     <= (int'(ble_data_in) > MSV) ? NW'(MSV) : NW'(ble_data_in);
                vec_cnt  <= '0;
                byte_cnt <= '0;
                bias_cnt <= '0;
            end
            if (wr_vec) begin
                if (vec_end) begin
                    byte_cnt <= '0;
                    vec_cnt  <= vec_cnt + 8'd1;
                end else begin
                    byte_cnt <= byte_cnt + BW'(1);
                end
            end
            if (wr_bias) begin
                bias[{bias_cnt, 3'b000} +: 8] <= ble_data_in;
                bias_cnt <= bias_cnt + 2'd1;
            end
        end
    end

    // vectors past the storage depth are consumed but not stored
    always_ff @(posedge clk_in) begin
        if (!rst_in && wr_vec && int'(vec_cnt) < MSV) begin
            if (int'(byte_cnt) < NF)
                sv_mem[vec_cnt[SVW-1:0]][byte_cnt[FW-1:0]] <= ble_data_in;
            else if (!vec_end)
                w_mem[vec_cnt[SVW-1:0]][7:0] <= ble_data_in;
            else
                w_mem[vec_cnt[SVW-1:0]][15:8] <= ble_data_in;
        end
    end

    // ---------------- feature capture ----------------
    assign accept   = feature_valid_in & predict_enable_in & (comp_state == C_IDLE);
    assign vec_done = accept & feature_last_in;
    assign start    = vec_done & model_loaded & ~abort;
    // buffer is held while scoring and cleared once the vector is finished with
    assign clear_buf = done_en | (abort & (comp_state != C_IDLE)) | (vec_done & ~start);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            feat_idx <= '0;
            for (int i = 0; i < NF; i++) feat_buf[i] <= '0;
        end else begin
            if (accept) begin
                if (int'(feat_idx) < NF)
                    feat_buf[feat_idx[FW-1:0]] <= feature_data_in;
                if (feature_last_in)
                    feat_idx <= '0;
                else if (int'(feat_idx) < NF)
                    feat_idx <= feat_idx + IW'(1);
            end
            if (clear_buf)
                for (int i = 0; i < NF; i++) feat_buf[i] <= '0;
        end
    end

    // ---------------- compute FSM ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) comp_state <= C_IDLE;
        else        comp_state <= comp_next;
    end

    always_comb begin
        comp_next = comp_state;
        case (comp_state)
            C_IDLE: if (start) comp_next = C_INIT;
            C_INIT: comp_next = (n_sv == '0) ? C_DONE : C_MAC;
            C_MAC:  if (feat_j == FW'(NF - 1)) comp_next = C_ADD;
            C_ADD:  comp_next = (sv_i == n_sv - NW'(1)) ? C_DONE : C_MAC;
            C_DONE: comp_next = C_IDLE;
            default: comp_next = C_IDLE;
        endcase
        if (abort) comp_next = C_IDLE;
    end

    always_comb begin
        init_en = (comp_state == C_INIT);
        mac_en  = (comp_state == C_MAC);
        add_en  = (comp_state == C_ADD);
        done_en = (comp_state == C_DONE) & ~abort;
    end

    assign sv_sel   = sv_i[SVW-1:0];
    assign sv_cur   = sv_mem[sv_sel][feat_j];
    assign x_cur    = feat_buf[feat_j];
    assign w_cur    = w_mem[sv_sel];
    assign mac_prod = $signed({{24{sv_cur[7]}}, sv_cur}) * $signed({{16{x_cur[15]}}, x_cur});
    assign add_prod = $signed({{32{w_cur[15]}}, w_cur}) * $signed({{16{acc[31]}}, acc});

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc          <= '0;
            score        <= '0;
            sv_i         <= '0;
            feat_j       <= '0;
            detected_out <= 1'b0;
        end else begin
            if (init_en) begin
                score  <= $signed({{16{bias[31]}}, bias});
                acc    <= '0;
                sv_i   <= '0;
                feat_j <= '0;
            end
            if (mac_en) begin
                acc    <= acc + mac_prod;
                feat_j <= (feat_j == FW'(NF - 1)) ? '0 : feat_j + FW'(1);
            end
            if (add_en) begin
                score <= score + add_prod;
                acc   <= '0;
                sv_i  <= sv_i + NW'(1);
            end
            if (done_en)
                detected_out <= (score > 48'sd0);
        end
    end

endmodule

// File: tb/tb_svm_classifier.sv
// Testbench for svm_classifier (NUM_FEATURES_IN=4, MAX_SUPPORT_VECTORS=3).
// Expected decisions come from a plain-arithmetic model of the classifier
// (score = bias + sum_i w_i * dot(sv_i, x)) plus a table of hand-computed cases.

module tb_svm_classifier;

    localparam int NF  = 4;
    localparam int MSV = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fdata;
    logic        fvalid, flast;
    logic [7:0]  bdata;
    logic        bvalid, pen;
    logic        det;

    always #5 clk = ~clk;

    svm_classifier #(.NUM_FEATURES_IN(NF), .MAX_SUPPORT_VECTORS(MSV)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .feature_data_in(fdata),
        .feature_valid_in(fvalid),
        .feature_last_in(flast),
        .ble_data_in(bdata),
        .ble_valid_in(bvalid),
        .predict_enable_in(pen),
        .detected_out(det)
    );

    int checks = 0;
    int errors = 0;

    // model
    int m_n;
    int m_sv [4][NF];
    int m_w  [4];
    int m_bias;
    bit loaded;
    int stored;
    bit prev;

    typedef struct { shortint d; bit en; } samp_t;
    samp_t sq[$];

    typedef struct { int model; int x0; int x1; int x2; int x3; bit expv; } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void push(input int d, input bit en);
        samp_t s;
        s.d  = shortint'(d);
        s.en = en;
        sq.push_back(s);
    endfunction

    task automatic idle_inputs();
        fvalid = 1'b0;
        flast  = 1'b0;
        pen    = 1'b1;
        fdata  = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bdata  = b;
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
    endtask

    task automatic upload();
        logic [7:0] q[$];
        q.push_back(8'(m_n));
        for (int v = 0; v < m_n; v++) begin
            for (int j = 0; j < NF; j++) q.push_back(8'(m_sv[v][j]));
            q.push_back(8'(m_w[v]));
            q.push_back(8'(m_w[v] >>> 8));
        end
        for (int k = 0; k < 4; k++) q.push_back(8'(m_bias >>> (8 * k)));
        foreach (q[i]) send_byte(q[i]);
        loaded = 1'b1;
        stored = (m_n > MSV) ? MSV : m_n;
    endtask

    task automatic clear_model();
        for (int v = 0; v < 4; v++) begin
            m_w[v] = 0;
            for (int j = 0; j < NF; j++) m_sv[v][j] = 0;
        end
    endtask

    task automatic load_model(input int sel);
        clear_model();
        case (sel)
            0: begin m_n = 1; m_sv[0][0] = 1; m_w[0] = 1; m_bias = 0; end
            1: begin m_n = 0; m_bias = 32'h21436507; end
            2: begin m_n = 0; m_bias = -1; end
            default: begin
                m_n = 2; m_sv[0][0] = 2; m_w[0] = 3;
                m_sv[1][1] = 1; m_w[1] = -1; m_bias = -10;
            end
        endcase
        upload();
    endtask

    // Drives the samples queued in sq (last flag on the final one), then checks
    // detected_out holds its old value until the expected latency and takes the
    // model's decision exactly then. With noise set, junk samples are driven
    // while the classifier is busy; they must be ignored.
    task automatic run_vector(input bit noise, input string tag);
        int     xv [NF];
        int     cnt;
        int     lat;
        int     kdot;
        longint score;
        bit     expv;
        bit     busy_noise;
        for (int j = 0; j < NF; j++) xv[j] = 0;
        cnt = 0;
        foreach (sq[i]) if (sq[i].en) begin
            if (cnt < NF) xv[cnt] = int'(sq[i].d);
            cnt++;
        end
        if (loaded) begin
            score = longint'(m_bias);
            for (int v = 0; v < stored; v++) begin
                kdot = 0;
                for (int j = 0; j < NF; j++) kdot += m_sv[v][j] * xv[j];
                score += longint'(m_w[v]) * longint'(kdot);
            end
            expv = (score > 0);
            lat  = stored * (NF + 1) + 2;
        end else begin
            expv = prev;
            lat  = 6;
        end
        busy_noise = noise && loaded;
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            fdata  = 16'(sq[i].d);
            fvalid = 1'b1;
            pen    = sq[i].en;
            flast  = (i == sq.size() - 1);
        end
        @(negedge clk);
        if (busy_noise) begin fvalid = 1'b1; flast = 1'b1; pen = 1'b1; fdata = 16'($urandom); end
        else idle_inputs();
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k < lat) check({tag, "_hold"}, det, prev);
            else         check({tag, "_result"}, det, expv);
            if (busy_noise && k < lat) begin
                fvalid = 1'b1; flast = 1'b1; pen = 1'b1; fdata = 16'($urandom);
            end else idle_inputs();
        end
        prev = expv;
        sq.delete();
    endtask

    initial begin
        rst = 1'b1;
        bdata = '0;
        bvalid = 1'b0;
        idle_inputs();
        loaded = 1'b0;
        stored = 0;
        prev = 1'b0;
        m_n = 0;
        m_bias = 0;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_det", det, 1'b0);

        // unloaded model: vector is discarded
        push(5, 1); push(6, 1); push(7, 1); push(8, 1);
        run_vector(1'b0, "unloaded");

        // table-driven cases with hand-computed decisions
        tbl[0]  = '{0,   5,   0, 0, 0, 1'b1};
        tbl[1]  = '{0,  -5,   0, 0, 0, 1'b0};
        tbl[2]  = '{0,   0,   0, 0, 0, 1'b0};
        tbl[3]  = '{1,   0,   0, 0, 0, 1'b1};
        tbl[4]  = '{1, -100,  7, 3, 1, 1'b1};
        tbl[5]  = '{2,   1,   2, 3, 4, 1'b0};
        tbl[6]  = '{3,   2,   1, 0, 0, 1'b1};
        tbl[7]  = '{3,   2,   3, 0, 0, 1'b0};
        tbl[8]  = '{3,   0, -20, 0, 0, 1'b1};
        tbl[9]  = '{3,   3,   0, 0, 0, 1'b1};
        tbl[10] = '{3,   1,   1, 0, 0, 1'b0};
        begin
            int cur;
            cur = -1;
            for (int i = 0; i < 11; i++) begin
                if (tbl[i].model != cur) begin
                    load_model(tbl[i].model);
                    cur = tbl[i].model;
                end
                push(tbl[i].x0, 1); push(tbl[i].x1, 1); push(tbl[i].x2, 1); push(tbl[i].x3, 1);
                run_vector(1'(i % 2), "tbl");
                check("tbl_expected", det, tbl[i].expv);
            end
        end

        // model 3 loaded, prev = 0: early last after two samples
        push(2, 1); push(1, 1);
        run_vector(1'b0, "early_last");
        check("early_last_val", det, 1'b1);

        // samples with predict_enable low are ignored
        push(100, 0); push(100, 0); push(2, 1); push(3, 1); push(0, 1); push(0, 1);
        run_vector(1'b0, "pen_low");
        check("pen_low_val", det, 1'b0);

        // samples past NUM_FEATURES_IN are dropped
        push(2, 1); push(1, 1); push(0, 1); push(0, 1); push(-50, 1); push(9, 1);
        run_vector(1'b1, "overflow");
        check("overflow_val", det, 1'b1);

        // new upload byte mid-compute aborts; detected_out holds
        push(2, 1); push(3, 1); push(0, 1); push(0, 1);
        foreach (sq[i]) begin
            @(negedge clk);
            fdata = 16'(sq[i].d); fvalid = 1'b1; pen = 1'b1; flast = (i == sq.size() - 1);
        end
        sq.delete();
        @(negedge clk);
        idle_inputs();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("abort_hold", det, prev);
            if (k == 3) begin bdata = 8'd0; bvalid = 1'b1; end
            else bvalid = 1'b0;
        end
        loaded = 1'b0;
        m_n = 0;
        clear_model();
        push(5, 1);
        run_vector(1'b0, "abort_unloaded");
        m_bias = -5;
        for (int k = 0; k < 4; k++) send_byte(8'(m_bias >>> (8 * k)));
        loaded = 1'b1;
        stored = 0;
        push(1, 1);
        run_vector(1'b1, "after_abort");
        check("after_abort_val", det, 1'b0);

        // reset drops the model and the result
        m_n = 0; m_bias = 100;
        upload();
        push(0, 1);
        run_vector(1'b0, "pre_reset");
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        loaded = 1'b0;
        prev = 1'b0;
        check("reset_again", det, 1'b0);
        push(3, 1);
        run_vector(1'b0, "post_reset_unloaded");

        // randomized models and vectors against the arithmetic model
        for (int it = 0; it < 24; it++) begin
            if (it % 4 == 0) begin
                clear_model();
                m_n = int'($urandom_range(0, 4));
                for (int v = 0; v < m_n; v++) begin
                    for (int j = 0; j < NF; j++) m_sv[v][j] = int'($urandom_range(0, 255)) - 128;
                    m_w[v] = int'($urandom_range(0, 65535)) - 32768;
                end
                m_bias = int'($urandom);
                upload();
            end
            begin
                int len;
                len = int'($urandom_range(1, 6));
                for (int s = 0; s < len; s++) begin
                    if ($urandom_range(0, 3) == 0) push(int'($urandom_range(0, 65535)) - 32768, 0);
                    push(int'($urandom_range(0, 65535)) - 32768, 1);
                end
            end
            run_vector(1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
